// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the instruction fetch stage
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        TRAP  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } fetch_pkt_t;

    // Sequential successor; wraps silently at the top of the address space.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// rtl/fetch_out_buf.sv - one-entry valid/ready holding register between fetch and decode
module fetch_out_buf
    import riscv_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  fetch_pkt_t load_pkt,
    input  logic       consume,
    input  logic       flush,
    output logic       valid,
    output fetch_pkt_t pkt
);

    fetch_pkt_t held;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            held  <= '{instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd0};
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            // A load in the same cycle as a consume refills the entry.
            valid <= 1'b1;
            held  <= load_pkt;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

    always_comb begin
        pkt = held;
        if (!valid) begin
            pkt.instr = NOP_INSTR;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC ownership, single-outstanding imem fetch and redirect handling
module pc_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    input  logic        id_ready,
    output logic        fetch_misaligned
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc;
    logic [31:0]  pc_inflight;
    logic         kill;
    logic         misaligned;

    logic         accept;
    logic         rsp;
    logic         outstanding;
    logic         redirect_bad;
    logic         buf_load;
    logic         buf_valid;
    fetch_pkt_t   buf_pkt;
    fetch_pkt_t   load_pkt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ISSUE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            // An in-flight word must drain in WAIT before TRAP or a new fetch.
            if (outstanding) begin
                state_nxt = WAIT;
            end else if (redirect_bad) begin
                state_nxt = TRAP;
            end else begin
                state_nxt = ISSUE;
            end
        end else begin
            case (state)
                ISSUE: if (accept) state_nxt = WAIT;
                WAIT:  if (imem_rvalid) state_nxt = misaligned ? TRAP : ISSUE;
                TRAP:  state_nxt = TRAP;
                default: state_nxt = ISSUE;
            endcase
        end
    end

    always_comb begin
        imem_req     = !rst && (state == ISSUE) && (!buf_valid || id_ready);
        accept       = imem_req && imem_ready;
        rsp          = (state == WAIT) && imem_rvalid;
        outstanding  = accept || ((state == WAIT) && !imem_rvalid);
        redirect_bad = redirect_target[1:0] != 2'b00;
        buf_load     = rsp && !kill && !redirect_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            pc_inflight <= RESET_PC;
            kill        <= 1'b0;
            misaligned  <= 1'b0;
        end else if (redirect_valid) begin
            pc         <= redirect_target;
            kill       <= outstanding;
            misaligned <= redirect_bad;
        end else begin
            if (accept) begin
                pc_inflight <= pc;
                pc          <= pc_inc(pc);
            end
            if (rsp) begin
                kill <= 1'b0;
            end
        end
    end

    always_comb begin
        load_pkt = '{instr: imem_rdata, pc: pc_inflight, pc_plus4: pc_inc(pc_inflight)};
    end

    fetch_out_buf #(
        .NOP_INSTR (NOP_INSTR)
    ) u_out_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (buf_load),
        .load_pkt (load_pkt),
        .consume  (buf_valid && id_ready),
        .flush    (redirect_valid),
        .valid    (buf_valid),
        .pkt      (buf_pkt)
    );

    assign imem_addr        = pc;
    assign if_valid         = buf_valid;
    assign if_instr         = buf_pkt.instr;
    assign if_pc            = buf_pkt.pc;
    assign if_pc_plus4      = buf_pkt.pc_plus4;
    assign fetch_misaligned = misaligned;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit with a transaction-level model
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RESET = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        id_ready;
    logic        fetch_misaligned;

    int compared   = 0;
    int mismatched = 0;

    // Model: next expected fetch address, next expected delivered pc, trap flag.
    logic [31:0] exp_fetch;
    logic [31:0] exp_deliver;
    bit          trap;
    // Memory: single pending response with programmable latency.
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat;
    bit          bad_data;
    bit          acc_seen;
    logic [31:0] acc_addr;
    logic [31:0] r;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .if_valid         (if_valid),
        .if_instr         (if_instr),
        .if_pc            (if_pc),
        .if_pc_plus4      (if_pc_plus4),
        .id_ready         (id_ready),
        .fetch_misaligned (fetch_misaligned)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        compared++;
        assert (obs === want) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // One clock: observe handshakes at negedge, update model, then drive memory after the edge.
    task automatic cyc();
        bit acc;
        bit cons;
        @(negedge clk);
        acc      = imem_req && imem_ready;
        cons     = if_valid && id_ready;
        acc_seen = acc;
        acc_addr = imem_addr;
        if (rst) begin
            chk("req_in_reset", 32'(imem_req), 32'd0);
            exp_fetch   = RESET;
            exp_deliver = RESET;
            trap        = 1'b0;
        end else begin
            if (acc) begin
                chk("fetch_addr", imem_addr, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
            end
            if (cons) begin
                chk("deliver_pc", if_pc, exp_deliver);
                chk("deliver_instr", if_instr, mem_word(exp_deliver));
                chk("deliver_pc_plus4", if_pc_plus4, exp_deliver + 32'd4);
                exp_deliver = exp_deliver + 32'd4;
            end
            if (!if_valid) chk("nop_when_invalid", if_instr, NOP);
            if (trap) begin
                chk("trap_req", 32'(imem_req), 32'd0);
                chk("trap_valid", 32'(if_valid), 32'd0);
            end
            if (redirect_valid) begin
                exp_fetch   = redirect_target;
                exp_deliver = redirect_target;
                trap        = redirect_target[1:0] != 2'b00;
            end
        end
        @(posedge clk);
        #1;
        chk("misaligned_flag", 32'(fetch_misaligned), 32'(trap));
        redirect_valid = 1'b0;
        if (acc) begin
            mem_pend = 1'b1;
            mem_cnt  = lat;
            mem_addr = acc_addr;
        end
        imem_rvalid = 1'b0;
        if (mem_pend) begin
            if (mem_cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = bad_data ? 32'hDEAD_BEEF : mem_word(mem_addr);
                mem_pend    = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
        mem_pend       = 1'b0;
        bad_data       = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
        chk({tag, "_if_instr"}, if_instr, NOP);
        chk({tag, "_if_pc"}, if_pc, 32'd0);
        chk({tag, "_if_pc_plus4"}, if_pc_plus4, 32'd0);
        chk({tag, "_misaligned"}, 32'(fetch_misaligned), 32'd0);
        chk({tag, "_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_addr"}, imem_addr, RESET);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!if_valid && n < 20) begin
            cyc();
            n++;
        end
        chk({tag, "_valid_timeout"}, 32'(if_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_target = 32'd0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'd0; id_ready = 1'b1;
        exp_fetch = RESET; exp_deliver = RESET; trap = 1'b0;
        mem_pend = 1'b0; mem_cnt = 0; mem_addr = 32'd0; lat = 1; bad_data = 1'b0;
        acc_seen = 1'b0; acc_addr = 32'd0; r = 32'd0;

        // Streaming fetch, 1-cycle memory latency
        do_reset();
        check_reset_vals("t1_reset");
        cyc();
        chk("t1_wait_req", 32'(imem_req), 32'd0);
        chk("t1_not_yet_valid", 32'(if_valid), 32'd0);
        cyc();
        chk("t1_valid0", 32'(if_valid), 32'd1);
        chk("t1_pc0", if_pc, 32'd0);
        chk("t1_instr0", if_instr, mem_word(32'd0));
        chk("t1_addr4", imem_addr, 32'd4);
        cyc();
        chk("t1_consumed", 32'(if_valid), 32'd0);
        cyc();
        chk("t1_pc4", if_pc, 32'd4);
        chk("t1_addr8", imem_addr, 32'd8);
        cyc();
        cyc();
        chk("t1_pc8", if_pc, 32'd8);
        chk("t1_pc8_plus4", if_pc_plus4, 32'd12);

        // Decode backpressure holds the buffer and blocks requests
        do_reset();
        id_ready = 1'b0;
        cyc();
        cyc();
        chk("t2_valid", 32'(if_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t2_hold_valid", 32'(if_valid), 32'd1);
            chk("t2_hold_noreq", 32'(imem_req), 32'd0);
            chk("t2_hold_pc", if_pc, 32'd0);
        end
        id_ready = 1'b1;
        #1;
        chk("t2_release_req", 32'(imem_req), 32'd1);
        chk("t2_release_addr", imem_addr, 32'd4);
        cyc();
        cyc();
        chk("t2_pc4", if_pc, 32'd4);

        // Redirect while waiting for addr 8; the returning word must be dropped
        do_reset();
        lat = 2;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (acc_seen && acc_addr == 32'd8) break;
        end
        chk("t3_accept8_timeout", acc_addr, 32'd8);
        bad_data = 1'b1;
        redirect_valid = 1'b1; redirect_target = 32'h100;
        cyc();
        bad_data = 1'b0;
        chk("t3_kill_noreq", 32'(imem_req), 32'd0);
        chk("t3_flushed", 32'(if_valid), 32'd0);
        cyc();
        chk("t3_dropped", 32'(if_valid), 32'd0);
        chk("t3_req", 32'(imem_req), 32'd1);
        chk("t3_addr", imem_addr, 32'h100);
        wait_valid("t3");
        chk("t3_pc", if_pc, 32'h100);
        chk("t3_instr", if_instr, mem_word(32'h100));

        // Misaligned redirect traps until an aligned one arrives
        imem_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h102;
        cyc();
        chk("t4_flag", 32'(fetch_misaligned), 32'd1);
        chk("t4_valid", 32'(if_valid), 32'd0);
        imem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t4_noreq", 32'(imem_req), 32'd0);
            chk("t4_flag_sticky", 32'(fetch_misaligned), 32'd1);
        end
        redirect_valid = 1'b1; redirect_target = 32'h200;
        cyc();
        chk("t4_flag_clear", 32'(fetch_misaligned), 32'd0);
        chk("t4_req", 32'(imem_req), 32'd1);
        chk("t4_addr", imem_addr, 32'h200);
        wait_valid("t4");
        chk("t4_pc", if_pc, 32'h200);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        cyc();
        wait_valid("t5a");
        chk("t5_pc_top", if_pc, 32'hFFFF_FFFC);
        chk("t5_plus4_wrap", if_pc_plus4, 32'd0);
        cyc();
        wait_valid("t5b");
        chk("t5_pc_zero", if_pc, 32'd0);
        chk("t5_plus4_four", if_pc_plus4, 32'd4);

        // Reset during WAIT followed by a stray response
        do_reset();
        lat = 2;
        cyc();
        chk("t6_accept", 32'(acc_seen), 32'd1);
        rst = 1'b1; imem_ready = 1'b0;
        cyc();
        rst = 1'b0;
        #1;
        check_reset_vals("t6_reset");
        cyc();
        chk("t6_stray_ignored", 32'(if_valid), 32'd0);
        chk("t6_stray_instr", if_instr, NOP);
        chk("t6_req", 32'(imem_req), 32'd1);
        chk("t6_addr", imem_addr, RESET);
        imem_ready = 1'b1; lat = 1;
        wait_valid("t6");
        chk("t6_pc", if_pc, RESET);
        chk("t6_instr", if_instr, mem_word(RESET));

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            imem_ready = $urandom_range(0, 3) != 0;
            id_ready   = $urandom_range(0, 9) < 7;
            lat        = $urandom_range(1, 3);
            if ($urandom_range(0, 15) == 0) begin
                r = $urandom;
                redirect_valid  = 1'b1;
                redirect_target = {20'h0, r[11:2], 2'b00};
                if (r[31:29] == 3'd0) redirect_target[1:0] = 2'b10;
                if (r[28:26] == 3'd0) redirect_target = 32'hFFFF_FFF8;
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
